// File: rtl/i2c_target.sv
// I2C target that turns bus transfers into single-cycle memory read/write strobes.
// Define I2C_TARGET_AUTOINC_EN to advance the pointer after every written or ACKed read byte.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         DATAWIDTH = 8,
  parameter int         ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 busy
);

`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEV_ACK, REGADDR, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic                 scl_meta_q, scl_sync_q, scl_prev_q;
  logic                 sda_meta_q, sda_sync_q, sda_prev_q;
  logic [1:0]           settle_q, settle_d;
  state_t               state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATAWIDTH-1:0] rx_q, rx_d;
  logic [DATAWIDTH-1:0] tx_q, tx_d;
  logic [ADDRWIDTH-1:0] ptr_q, ptr_d;
  logic                 rw_q, rw_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 busy_q, busy_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic                 mem_rd_en_q, mem_rd_en_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [ADDRWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATAWIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // Bus events are suppressed until the synchronizer and history flops hold real bus values,
  // so a reset released mid-transfer cannot fabricate a START.
  logic bus_ok, scl_rise, scl_fall, start_det, stop_det;
  assign bus_ok    = (settle_q == 2'd3);
  assign scl_rise  = bus_ok &  scl_sync_q & ~scl_prev_q;
  assign scl_fall  = bus_ok & ~scl_sync_q &  scl_prev_q;
  assign start_det = bus_ok & scl_sync_q & scl_prev_q &  sda_prev_q & ~sda_sync_q;
  assign stop_det  = bus_ok & scl_sync_q & scl_prev_q & ~sda_prev_q &  sda_sync_q;

  logic [DATAWIDTH-1:0] rx_byte;
  logic [ADDRWIDTH-1:0] ptr_inc;
  assign rx_byte = {rx_q[DATAWIDTH-2:0], sda_sync_q};
  assign ptr_inc = ptr_q + ADDRWIDTH'(1);

  always_comb begin
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = rd_valid_q ? mem_rdata : tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    mem_wr_en_d = 1'b0;
    mem_rd_en_d = 1'b0;
    rd_valid_d  = mem_rd_en_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = DEVADDR;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        IDLE, IGNORE: ;
        DEVADDR: begin
          if (scl_rise) begin
            rx_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              rw_d      = sda_sync_q;
              if (rx_byte[DATAWIDTH-1:1] == DEV_ADDR) begin
                state_d = DEV_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
          end
        end
        REGADDR: begin
          if (scl_rise) begin
            rx_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ptr_d     = rx_byte[ADDRWIDTH-1:0];
              state_d   = REG_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            rx_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d   = 4'd0;
              mem_wr_en_d = 1'b1;
              mem_addr_d  = ptr_q;
              mem_wdata_d = rx_byte;
              if (AUTOINC) ptr_d = ptr_inc;
              state_d     = WDATA_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (scl_fall) begin
            sda_oe_d = 1'b0;
          end
        end
        // Ack phases: bit_cnt 0 = waiting for the falling edge that opens the ack slot,
        // 1 = ack clock seen, next falling edge closes the slot.
        DEV_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall && bit_cnt_q == 4'd0) begin
            sda_oe_d = 1'b1;
          end else if (scl_rise && bit_cnt_q == 4'd0 && sda_oe_q) begin
            bit_cnt_d = 4'd1;
            if (state_q == DEV_ACK && rw_q) begin
              mem_rd_en_d = 1'b1;
              mem_addr_d  = ptr_q;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd0;
            if (state_q == DEV_ACK && rw_q) begin
              state_d  = RDATA;
              sda_oe_d = ~tx_q[DATAWIDTH-1];
            end else begin
              state_d  = (state_q == DEV_ACK) ? REGADDR : WDATA;
              sda_oe_d = 1'b0;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
              state_d   = RDATA_ACK;
            end else begin
              tx_d     = {tx_q[DATAWIDTH-2:0], 1'b0};
              sda_oe_d = ~tx_q[DATAWIDTH-2];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise && bit_cnt_q == 4'd0) begin
            if (sda_sync_q) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end else begin
              bit_cnt_d   = 4'd1;
              mem_rd_en_d = 1'b1;
              mem_addr_d  = AUTOINC ? ptr_inc : ptr_q;
              if (AUTOINC) ptr_d = ptr_inc;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd0;
            state_d   = RDATA;
            sda_oe_d  = ~tx_q[DATAWIDTH-1];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_meta_q  <= 1'b1;
      scl_sync_q  <= 1'b1;
      scl_prev_q  <= 1'b1;
      sda_meta_q  <= 1'b1;
      sda_sync_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      settle_q    <= 2'd0;
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      rx_q        <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      scl_meta_q  <= scl_in;
      scl_sync_q  <= scl_meta_q;
      scl_prev_q  <= scl_sync_q;
      sda_meta_q  <= sda_in;
      sda_sync_q  <= sda_meta_q;
      sda_prev_q  <= sda_sync_q;
      settle_q    <= settle_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      rd_valid_q  <= rd_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C controller, attached memory, and a transaction-level model.
// Follows the I2C_TARGET_AUTOINC_EN build setting for its expected addresses.
module tb_i2c_target;
  localparam int Q = 60;

`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  wire        scl_in;
  wire        sda_in;
  logic       sda_oe, mem_wr_en, mem_rd_en, busy;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_target dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Attached memory with registered read.
  logic [7:0] tb_mem [256];
  always @(posedge clk) begin
    if (mem_wr_en) tb_mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= tb_mem[mem_addr];
  end

  // Strobe and drive log, sampled mid-cycle.
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic [7:0] wr_a_log [1024];
  logic [7:0] wr_d_log [1024];
  logic [7:0] rd_a_log [1024];
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_a_log[wr_cnt % 1024] <= mem_addr;
      wr_d_log[wr_cnt % 1024] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_rd_en) begin
      rd_a_log[rd_cnt % 1024] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_wr_en && mem_rd_en) both_cnt <= both_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte i of a transfer starting at a lands at a+i (mod 256) or at a.
  logic [7:0] model_mem [256];
  logic [7:0] wbuf [4];

  function automatic logic [7:0] step_addr(input logic [7:0] a, input int i);
    return AUTOINC ? 8'(32'(a) + i) : a;
  endfunction

  task automatic write_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_in; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(r);
    ack = ~r;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      read_bit(r);
      b[i] = r;
    end
    write_bit(nack);
  endtask

  task automatic do_write(input logic [7:0] a, input int n);
    int   wr0;
    logic ack;
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, ack);  chk("wr_dev_ack", 32'(ack), 32'd1);
    send_byte(a, ack);      chk("wr_reg_ack", 32'(ack), 32'd1);
    chk("wr_busy_high", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack);
      chk("wr_data_ack", 32'(ack), 32'd1);
      model_mem[step_addr(a, i)] = wbuf[i];
    end
    i2c_stop();
    #(4*Q);
    chk("wr_busy_after_stop", 32'(busy), 32'd0);
    chk("wr_strobe_count", 32'(wr_cnt - wr0), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", 32'(wr_a_log[(wr0 + i) % 1024]), 32'(step_addr(a, i)));
      chk("wr_data", 32'(wr_d_log[(wr0 + i) % 1024]), 32'(wbuf[i]));
    end
    $display("write a=%02h n=%0d", a, n);
  endtask

  task automatic do_read(input logic [7:0] a, input int n);
    int         rd0, wr0;
    logic       ack;
    logic [7:0] b;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, ack);  chk("rd_dev_ack_w", 32'(ack), 32'd1);
    send_byte(a, ack);      chk("rd_reg_ack", 32'(ack), 32'd1);
    i2c_start();
    send_byte(8'hA1, ack);  chk("rd_dev_ack_r", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      recv_byte(b, (i == n - 1));
      chk("rd_data", 32'(b), 32'(model_mem[step_addr(a, i)]));
    end
    chk("rd_busy_after_nack", 32'(busy), 32'd0);
    i2c_stop();
    #(4*Q);
    chk("rd_strobe_count", 32'(rd_cnt - rd0), 32'(n));
    chk("rd_no_write", 32'(wr_cnt - wr0), 32'd0);
    for (int i = 0; i < n; i++)
      chk("rd_addr", 32'(rd_a_log[(rd0 + i) % 1024]), 32'(step_addr(a, i)));
    $display("read  a=%02h n=%0d", a, n);
  endtask

  task automatic do_mismatch(input logic [7:0] dev_byte, input logic [7:0] b2);
    int   oe0, busy0, wr0, rd0;
    logic ack;
    oe0 = oe_cnt; busy0 = busy_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
    i2c_start();
    send_byte(dev_byte, ack); chk("mm_dev_nack", 32'(ack), 32'd0);
    send_byte(b2, ack);       chk("mm_byte_nack", 32'(ack), 32'd0);
    i2c_stop();
    #(4*Q);
    chk("mm_no_drive", 32'(oe_cnt - oe0), 32'd0);
    chk("mm_no_busy", 32'(busy_cnt - busy0), 32'd0);
    chk("mm_no_strobe", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
    $display("mismatch dev=%02h", dev_byte);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: run did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ack, r;
    logic [7:0] a, b;
    int         n, wr0, rd0, oe0;
    logic [6:0] dev;

    // Bus activity while held in reset must have no effect.
    repeat (3) @(posedge clk);
    i2c_start();
    for (int i = 0; i < 5; i++) write_bit(i[0]);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    i2c_stop();
    @(negedge clk) reset = 1'b1;
    #(4*Q);
    chk("idle_no_strobe", 32'(wr_cnt + rd_cnt), 32'd0);
    $display("reset phase done");

    // Basic write, then read back a known byte.
    wbuf[0] = 8'h5A;
    do_write(8'h12, 1);
    wbuf[0] = 8'hC3;
    do_write(8'h12, 1);
    do_read(8'h12, 1);

    // Foreign device address.
    do_mismatch(8'hA2, 8'h00);

    // Burst across the top of the address space.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(8'hFF, 2);

    // Abort after four data bits; following bits without START must be ignored.
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h30, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    #(4*Q);
    chk("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    oe0 = oe_cnt;
    for (int i = 7; i >= 0; i--) write_bit(i[0]);
    read_bit(r);
    chk("abort_idle_no_ack", 32'(r), 32'd1);
    chk("abort_idle_no_drive", 32'(oe_cnt - oe0), 32'd0);
    $display("abort done");

    // Randomized transfers checked against the model.
    for (int it = 0; it < 5; it++) begin
      a = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
      do_write(a, n);
      do_read(a, $urandom_range(1, n));
      dev = 7'($urandom_range(0, 127));
      if (dev == 7'h50) dev = 7'h51;
      do_mismatch({dev, 1'($urandom_range(0, 1))}, 8'($urandom_range(0, 255)));
    end

    // Reset while the target drives a read bit, then released mid-transfer.
    wbuf[0] = 8'h00;
    do_write(8'h40, 1);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h40, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    chk("midread_driving", 32'(sda_oe), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("midread_async_release", 32'(sda_oe), 32'd0);
    chk("midread_busy_clear", 32'(busy), 32'd0);
    #(2*Q);
    reset = 1'b1;
    oe0 = oe_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    for (int i = 0; i < 9; i++) read_bit(r);
    chk("resume_no_drive", 32'(oe_cnt - oe0), 32'd0);
    chk("resume_no_strobe", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
    do_read(8'h40, 1);
    $display("mid-read reset done");

    chk("no_wr_rd_overlap", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
